// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry layout, PC step.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_RELEASE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush; flush overrides everything.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !flush && reset;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers are exactly PW bits wide so they wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-at-a-time level-handshake cache requests, fetch queue.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int INSTR_WIDTH = FETCH_INSTR_W,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  entry_pc,
  output logic                   read_enable,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [INSTR_WIDTH-1:0] data_out,
  input  logic                   send_enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   fetch_busy,
`ifdef FETCH_STATS_EN
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_dropped,
  output logic [31:0]            stat_stall,
`endif
  output fetch_state_t           debug_state
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t           state;
  fetch_state_t           next_state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic [ADDR_WIDTH-1:0]  next_address;
  logic                   drop;
  logic                   next_drop;
  logic                   accept;
  logic                   push;
  logic                   discard;
  logic                   pop;
  logic                   queue_room;
  logic [CW-1:0]          count;
  fetch_entry_t           head;
  fetch_entry_t           push_entry;
  logic                   unused_low_bits;

  assign unused_low_bits = ^{entry_pc[1:0], redirect_pc[1:0]};

  // Cache side: read_enable/send_enable are levels; a request stays up until
  // send_enable rises, and the next one waits until send_enable falls.
  // Decode side: an entry transfers on any edge where out_valid && out_ready.
  assign read_enable = (state == FETCH_REQ);
  assign fetch_busy  = (state != FETCH_IDLE);
  assign debug_state = state;

  assign queue_room = (count < CW'(QUEUE_DEPTH));
  assign accept     = (state == FETCH_REQ) && send_enable;
  assign push       = accept && !drop && !redirect_valid;
  assign discard    = accept && (drop || redirect_valid);
  assign pop        = out_valid && out_ready;

  assign push_entry = '{pc: address, instr: data_out};

  assign out_valid = (count != '0) && !redirect_valid;
  assign out_pc    = (count != '0) ? head.pc : '0;
  assign out_instr = (count != '0) ? head.instr : '0;

  always_comb begin
    next_state   = state;
    next_pc      = pc;
    next_address = address;
    next_drop    = drop;
    case (state)
      FETCH_IDLE: begin
        if (queue_room && !redirect_valid) begin
          next_state   = FETCH_REQ;
          next_address = pc;
        end
      end
      FETCH_REQ: begin
        if (send_enable) begin
          next_state = FETCH_RELEASE;
          next_drop  = 1'b0;
          if (push) next_pc = pc + ADDR_WIDTH'(PC_STEP);
        end else if (redirect_valid) begin
          next_drop = 1'b1;
        end
      end
      FETCH_RELEASE: begin
        if (!send_enable) next_state = FETCH_IDLE;
      end
      default: next_state = FETCH_IDLE;
    endcase
    if (redirect_valid) next_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= FETCH_IDLE;
      pc      <= {entry_pc[ADDR_WIDTH-1:2], 2'b00};
      address <= {entry_pc[ADDR_WIDTH-1:2], 2'b00};
      drop    <= 1'b0;
    end else begin
      state   <= next_state;
      pc      <= next_pc;
      address <= next_address;
      drop    <= next_drop;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && (stat_fetched != 32'hFFFF_FFFF)) stat_fetched <= stat_fetched + 32'd1;
      if (discard && (stat_dropped != 32'hFFFF_FFFF)) stat_dropped <= stat_dropped + 32'd1;
      if ((state == FETCH_IDLE) && !queue_room && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction cache. Holds the program counter and issues one instruction request at a time over the cache's level-handshake (`read_enable`/`send_enable`). Returned instructions, tagged with their PC, are buffered in a small queue toward decode. Branch redirects flush the queue and steer the PC, discarding any instruction already in flight.

## Interface
- `ADDR_WIDTH`, 64, PC / cache address width
- `INSTR_WIDTH`, 32, instruction width, matches cache `data_out`
- `QUEUE_DEPTH`, 4, fetch queue entries; power of 2, ≥2
- `clock` in 1: single clock; all logic on posedge
- `reset` in 1: synchronous, active-low; reset applied when `reset==0` at posedge
- `entry_pc` in ADDR_WIDTH: PC loaded while in reset; bits [1:0] ignored
- `read_enable` out 1: request to cache
- `address` out ADDR_WIDTH: request PC, stable while `read_enable` high
- `data_out` in INSTR_WIDTH: instruction from cache, valid when `send_enable` high
- `send_enable` in 1: cache data-ready
- `redirect_valid` in 1: single-cycle redirect pulse
- `redirect_pc` in ADDR_WIDTH: new PC; bits [1:0] ignored
- `out_valid` out 1: queue head valid to decode
- `out_ready` in 1: decode accepts head
- `out_pc` out ADDR_WIDTH, `out_instr` out INSTR_WIDTH: queue head
- `fetch_busy` out 1: state ≠ FETCH_IDLE

## Operation
- Reset values: `read_enable`=0, `address`={entry_pc[63:2],2'b00}, `out_valid`=0, `out_pc`=0, `out_instr`=0, `fetch_busy`=0, queue empty, drop flag 0, state FETCH_IDLE.
- FETCH_IDLE: if queue count < QUEUE_DEPTH and no redirect this cycle → FETCH_REQ, latch `address`←pc. A slot is reserved at issue; push never overflows.
- FETCH_REQ: `read_enable`=1. On `send_enable`=1: if drop flag clear, push {address, data_out} and pc←pc+4; if drop set, discard, clear drop. → FETCH_RELEASE.
- FETCH_RELEASE: `read_enable`=0; when `send_enable`=0 → FETCH_IDLE.
- Cache handshake must complete; a request is never withdrawn while `send_enable`=0.
- Redirect: pc←{redirect_pc[63:2],2'b00}, queue flushed at next edge; `out_valid` forced 0 in redirect cycle. In FETCH_REQ: drop flag set, in-flight instruction discarded, pc not incremented.
- Redirect with `send_enable` in same FETCH_REQ cycle: instruction discarded, pc=redirect_pc.
- Redirect with pop same cycle: flush wins.
- Push and pop same cycle: count unchanged.
- pc+4 wraps modulo 2^ADDR_WIDTH.

## Timing
- Hit path: IDLE (c0) → REQ, `read_enable` high c1 → cache `send_enable` c2 → push at c2 edge, `out_valid` high c3 → RELEASE → IDLE. ~4 cycles/instruction.
- Redirect → first request with new PC ≤2 cycles after handshake release.
- `out_*` registered from queue head; no combinational path `send_enable`→`out_valid`.

## Configuration
- `FETCH_STATS_EN`: defined → adds outputs `stat_fetched` (32b, pushes), `stat_dropped` (32b, discarded returns), `stat_stall` (32b, IDLE cycles with full queue); saturating, cleared by reset. Undefined → ports and counters absent; behaviour otherwise identical.

## Structure
- `fetch_pkg`: `fetch_state_t` enum (FETCH_IDLE, FETCH_REQ, FETCH_RELEASE), `fetch_entry_t` struct {pc, instr}, `PC_STEP`=4.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, push/pop/flush, count, power-of-2 pointer wrap.

## Test plan
- Reset with entry_pc=0x1000, cache hit every request, out_ready=1 → out_pc 0x1000, 0x1004, 0x1008 with matching instrs, no gaps beyond 4-cycle cadence.
- out_ready=0, QUEUE_DEPTH=4 → exactly 4 pushes, `read_enable` stays 0 after, then one pop → one new request at pc 0x1010.
- redirect_pc=0x2003 while in FETCH_REQ, send_enable 3 cycles later → returned instr discarded, next out_pc=0x2000.
- redirect coincident with send_enable and out_ready pop → queue empty, pc 0x2000, no stale output.
- Cache miss holding send_enable low 40 cycles → read_enable and address stable throughout, single push.
- Reset asserted mid-FETCH_REQ → all outputs return to reset values next edge; with FETCH_STATS_EN, counters 0.
